// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the register file: zero-fills every register after reset,
// then round-robin arbitrates ALU (A) and load-return (B) writebacks. Option: REGFILE_R0_ZERO_EN.
module regfile_wr_sched #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aValid,
    input  logic [ADDR_W-1:0] aAddr,
    input  logic [DATA_W-1:0] aData,
    output logic              aReady,
    input  logic              bValid,
    input  logic [ADDR_W-1:0] bAddr,
    input  logic [DATA_W-1:0] bData,
    output logic              bReady,
    output logic              write,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [DATA_W-1:0] wrData,
    output logic              initDone
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    state_t            state;
    logic [ADDR_W-1:0] initCnt;
    logic              lastGrantB;

    // Accepted writes to r0 are swallowed when r0 is hardwired to zero.
    function automatic logic isDropped(input logic [ADDR_W-1:0] addr);
        return R0_ZERO && (addr == '0);
    endfunction

    assign aReady = (state == RUN) && aValid && (!bValid || lastGrantB);
    assign bReady = (state == RUN) && bValid && (!aValid || !lastGrantB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            initCnt    <= '0;
            lastGrantB <= 1'b1;
            write      <= 1'b0;
            wrAddr     <= '0;
            wrData     <= '0;
            initDone   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    write   <= 1'b1;
                    wrAddr  <= initCnt;
                    wrData  <= '0;
                    initCnt <= initCnt + ADDR_W'(1);
                    if (initCnt == LAST_ADDR) begin
                        state    <= RUN;
                        initDone <= 1'b1;
                    end
                end
                RUN: begin
                    // Address/data hold their last values on idle or dropped cycles.
                    if (aValid && aReady) begin
                        write      <= !isDropped(aAddr);
                        lastGrantB <= 1'b0;
                        if (!isDropped(aAddr)) begin
                            wrAddr <= aAddr;
                            wrData <= aData;
                        end
                    end else if (bValid && bReady) begin
                        write      <= !isDropped(bAddr);
                        lastGrantB <= 1'b1;
                        if (!isDropped(bAddr)) begin
                            wrAddr <= bAddr;
                            wrData <= bData;
                        end
                    end else begin
                        write <= 1'b0;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wr_sched.sv
// Bench for regfile_wr_sched: init zero-fill, arbitration vector table, reset corner cases.
module tb_regfile_wr_sched;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int NUM_REGS = 32;
`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0 = 1'b1;
`else
    localparam bit R0 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic aValid, bValid, aReady, bReady, write, initDone;
    logic [ADDR_W-1:0] aAddr, bAddr, wrAddr;
    logic [DATA_W-1:0] aData, bData, wrData;

    regfile_wr_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst),
        .aValid(aValid), .aAddr(aAddr), .aData(aData), .aReady(aReady),
        .bValid(bValid), .bAddr(bAddr), .bData(bData), .bReady(bReady),
        .write(write), .wrAddr(wrAddr), .wrData(wrData), .initDone(initDone)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              aV;
        logic [ADDR_W-1:0] aA;
        logic [DATA_W-1:0] aD;
        logic              bV;
        logic [ADDR_W-1:0] bA;
        logic [DATA_W-1:0] bD;
        logic              expA;
        logic              expB;
    } vec_t;

    typedef struct {
        logic              w;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [ADDR_W-1:0] heldAddr;
    logic [DATA_W-1:0] heldData;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic aV, input logic [ADDR_W-1:0] aA, input logic [DATA_W-1:0] aD,
                                input logic bV, input logic [ADDR_W-1:0] bA, input logic [DATA_W-1:0] bD,
                                input logic eA, input logic eB);
        vec_t v;
        v.aV = aV; v.aA = aA; v.aD = aD; v.bV = bV; v.bA = bA; v.bD = bD; v.expA = eA; v.expB = eB;
        return v;
    endfunction

    task automatic checkResetState();
        chk("rst_write", 64'(write), 64'(0));
        chk("rst_wrAddr", 64'(wrAddr), 64'(0));
        chk("rst_wrData", wrData, 64'(0));
        chk("rst_initDone", 64'(initDone), 64'(0));
        chk("rst_aReady", 64'(aReady), 64'(0));
        chk("rst_bReady", 64'(bReady), 64'(0));
    endtask

    // Checks nW init writes; drives a B request after the check of cycle bAt.
    task automatic runInit(input int bAt, input int nW);
        for (int i = 0; i < nW; i++) begin
            @(posedge clk); #1;
            chk($sformatf("init_write[%0d]", i), 64'(write), 64'(1));
            chk($sformatf("init_wrAddr[%0d]", i), 64'(wrAddr), 64'(i));
            chk($sformatf("init_wrData[%0d]", i), wrData, 64'(0));
            chk($sformatf("init_done[%0d]", i), 64'(initDone), 64'(i == NUM_REGS - 1));
            chk($sformatf("init_aReady[%0d]", i), 64'(aReady), 64'(0));
            chk($sformatf("init_bReady[%0d]", i), 64'(bReady), 64'((i == NUM_REGS - 1) && bValid));
            if (i == bAt) begin
                bValid = 1'b1; bAddr = 5'd12; bData = 64'hB0B;
            end
        end
    endtask

    task automatic runTable();
        exp_t e, got;
        heldAddr = 5'(NUM_REGS - 1);
        heldData = '0;
        for (int k = 0; k < 13; k++) begin
            aValid = vecs[k].aV; aAddr = vecs[k].aA; aData = vecs[k].aD;
            bValid = vecs[k].bV; bAddr = vecs[k].bA; bData = vecs[k].bD;
            #1;
            chk($sformatf("vec%0d_aReady", k), 64'(aReady), 64'(vecs[k].expA));
            chk($sformatf("vec%0d_bReady", k), 64'(bReady), 64'(vecs[k].expB));
            chk($sformatf("vec%0d_oneHot", k), 64'(aReady && bReady), 64'(0));
            e.w = 1'b0; e.addr = heldAddr; e.data = heldData;
            if (vecs[k].expA && !(R0 && vecs[k].aA == 0)) begin
                e.w = 1'b1; e.addr = vecs[k].aA; e.data = vecs[k].aD;
            end else if (vecs[k].expB && !(R0 && vecs[k].bA == 0)) begin
                e.w = 1'b1; e.addr = vecs[k].bA; e.data = vecs[k].bD;
            end
            heldAddr = e.addr; heldData = e.data;
            sb.push_back(e);
            @(posedge clk); #1;
            got = sb.pop_front();
            chk($sformatf("vec%0d_write", k), 64'(write), 64'(got.w));
            chk($sformatf("vec%0d_wrAddr", k), 64'(wrAddr), 64'(got.addr));
            chk($sformatf("vec%0d_wrData", k), wrData, got.data);
        end
        aValid = 1'b0; bValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 1, 0);
        vecs[1]  = mk(1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 0, 1);
        vecs[2]  = mk(1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 1, 0);
        vecs[3]  = mk(1, 5'd1, 64'h11, 1, 5'd2, 64'h22, 0, 1);
        vecs[4]  = mk(1, 5'd5, 64'hDEAD_BEEF, 0, 5'd0, 64'h0, 1, 0);
        vecs[5]  = mk(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 0);
        vecs[6]  = mk(0, 5'd0, 64'h0, 1, 5'd7, 64'h77, 0, 1);
        vecs[7]  = mk(0, 5'd0, 64'h0, 1, 5'd0, 64'hFF, 0, 1);
        vecs[8]  = mk(1, 5'd3, 64'h33, 1, 5'd4, 64'h44, 1, 0);
        vecs[9]  = mk(1, 5'd0, 64'hFF, 0, 5'd0, 64'h0, 1, 0);
        vecs[10] = mk(0, 5'd0, 64'h0, 1, 5'd9, 64'h99, 0, 1);
        vecs[11] = mk(1, 5'd10, 64'hAA, 1, 5'd11, 64'hBB, 1, 0);
        vecs[12] = mk(0, 5'd0, 64'h0, 0, 5'd0, 64'h0, 0, 0);

        rst = 1'b1;
        aValid = 1'b0; aAddr = '0; aData = '0;
        bValid = 1'b0; bAddr = '0; bData = '0;
        repeat (2) @(posedge clk);
        #1 checkResetState();
        @(negedge clk) rst = 1'b0;
        runInit(-1, NUM_REGS);
        runTable();

        // B requested mid-init is held off until RUN, then granted first.
        rst = 1'b1;
        #1 checkResetState();
        @(negedge clk) rst = 1'b0;
        runInit(10, NUM_REGS);
        @(posedge clk); #1;
        chk("lateB_write", 64'(write), 64'(1));
        chk("lateB_wrAddr", 64'(wrAddr), 64'(12));
        chk("lateB_wrData", wrData, 64'hB0B);
        bValid = 1'b0;
        @(posedge clk); #1;
        chk("lateB_idle", 64'(write), 64'(0));

        // Asynchronous reset with initCnt at 17, then a full restart.
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        runInit(-1, 17);
        #2 rst = 1'b1;
        #1;
        chk("midInit_write", 64'(write), 64'(0));
        chk("midInit_wrAddr", 64'(wrAddr), 64'(0));
        chk("midInit_initDone", 64'(initDone), 64'(0));
        @(negedge clk) rst = 1'b0;
        runInit(-1, NUM_REGS);
        @(posedge clk); #1;
        chk("postInit_idle", 64'(write), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
